sub_pipe: RTL and testbench

- Two-stage pipelined subtractor with valid/ready handshakes on input and output.
- Inverse companion of the convolution engine's 8-bit Add unit: computes dataa - datab, producing a registered result and a borrow flag.
- Sits between operand sources and the accumulate/offset-removal path.
- Sustains one operation per clock when not back-pressured; also counts completed results.

---
 rtl/sub_pipe.sv | 82 ++++++++
 tb/tb_sub_pipe.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_pipe.sv
// Two-stage valid/ready pipelined subtractor (dataa - datab) with borrow and a completed-op counter.
// Optional build macro SUB_PIPE_SATURATE_EN clamps an underflowing result to zero.
module sub_pipe #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clock,
    input  logic             aclr_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] dataa,
    input  logic [WIDTH-1:0] datab,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             borrow,
    output logic [CNT_W-1:0] ops_done
);

    logic             s1_valid;
    logic             s2_valid;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic             s2_free;
    logic             s1_adv;
    logic             in_xfer;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] result_next;

    always_comb begin
        s2_free  = !s2_valid || out_ready;
        s1_adv   = s1_valid && s2_free;
        in_ready = !s1_valid || s1_adv;
        in_xfer  = in_valid && in_ready;
        diff     = {1'b0, a_q} - {1'b0, b_q};
`ifdef SUB_PIPE_SATURATE_EN
        result_next = diff[WIDTH] ? '0 : diff[WIDTH-1:0];
`else
        result_next = diff[WIDTH-1:0];
`endif
    end

    assign out_valid = s2_valid;

    // Stage 1 may reload in the same edge that it hands its pair to stage 2.
    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            s1_valid <= 1'b0;
            a_q      <= '0;
            b_q      <= '0;
        end else if (in_xfer) begin
            s1_valid <= 1'b1;
            a_q      <= dataa;
            b_q      <= datab;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            s2_valid <= 1'b0;
            result   <= '0;
            borrow   <= 1'b0;
        end else if (s1_adv) begin
            s2_valid <= 1'b1;
            result   <= result_next;
            borrow   <= diff[WIDTH];
        end else if (out_ready) begin
            s2_valid <= 1'b0;
        end
    end

    always_ff @(posedge clock or negedge aclr_n) begin
        if (!aclr_n) begin
            ops_done <= '0;
        end else if (s2_valid && out_ready) begin
            ops_done <= ops_done + 1'b1;
        end
    end

endmodule

// File: tb/tb_sub_pipe.sv
// Self-checking bench for sub_pipe: queue-based reference model plus directed literal cases.
module tb_sub_pipe;

    localparam int W  = 8;
    localparam int CW = 4;

`ifdef SUB_PIPE_SATURATE_EN
    localparam logic [8:0] EXP_3_10 = 9'h100;
    localparam logic [8:0] EXP_5_9  = 9'h100;
`else
    localparam logic [8:0] EXP_3_10 = 9'h1F9;
    localparam logic [8:0] EXP_5_9  = 9'h1FC;
`endif

    logic          clock;
    logic          aclr_n;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  dataa;
    logic [W-1:0]  datab;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  result;
    logic          borrow;
    logic [CW-1:0] ops_done;

    sub_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clock(clock), .aclr_n(aclr_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .dataa(dataa), .datab(datab),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .borrow(borrow), .ops_done(ops_done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_pass = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    function automatic logic [8:0] model(input int a, input int b);
        int d;
        d = a - b;
        if (d < 0) begin
`ifdef SUB_PIPE_SATURATE_EN
            return {1'b1, 8'd0};
`else
            return {1'b1, 8'(d + 256)};
`endif
        end
        return {1'b0, 8'(d)};
    endfunction

    logic [8:0] exp_q[$];
    int         acc_t[$];
    logic [8:0] got[$];
    int         cyc = 0;
    int         delivered = 0;

    always @(negedge aclr_n) begin
        exp_q.delete();
        acc_t.delete();
        got.delete();
        delivered = 0;
    end

    always @(posedge clock) begin
        logic [8:0] e;
        int         t;
        if (aclr_n) begin
            cyc++;
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("spurious_output", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    t = acc_t.pop_front();
                    check("result", 32'(result), 32'(e[7:0]));
                    check("borrow", 32'(borrow), 32'(e[8]));
                    got.push_back({borrow, result});
                    delivered++;
                end
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(model(int'(dataa), int'(datab)));
                acc_t.push_back(cyc);
            end
        end
    end

    always @(negedge clock) begin
        if (aclr_n) begin
            check("ops_done", 32'(ops_done), 32'(delivered % 16));
            check("occupancy_le2", 32'(exp_q.size() <= 2), 32'd1);
            if (exp_q.size() < 2) check("in_ready_free", 32'(in_ready), 32'd1);
            else                  check("in_ready_full", 32'(in_ready), 32'(out_ready));
            if (exp_q.size() == 0)   check("out_valid_idle", 32'(out_valid), 32'd0);
            else if (acc_t[0] == cyc) check("latency_early", 32'(out_valid), 32'd0);
            else                      check("latency_due", 32'(out_valid), 32'd1);
        end
    end

    task automatic do_reset();
        @(negedge clock);
        #1 aclr_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_borrow", 32'(borrow), 32'd0);
        check("rst_ops_done", 32'(ops_done), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        #1 aclr_n = 1'b1;
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, output int edges);
        logic ok;
        dataa = a;
        datab = b;
        in_valid = 1'b1;
        edges = 0;
        ok = 1'b0;
        while (!ok && edges < 40) begin
            @(posedge clock);
            ok = in_ready;
            edges++;
        end
        if (!ok) check("send_timeout", 32'(ok), 32'd1);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clock);
            n++;
        end
        #1;
        check("drain", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int e;
        int base;
        aclr_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        dataa = '0;
        datab = '0;
        #2;
        check("init_out_valid", 32'(out_valid), 32'd0);
        check("init_ops_done", 32'(ops_done), 32'd0);
        check("init_in_ready", 32'(in_ready), 32'd1);
        @(negedge clock) aclr_n = 1'b1;
        @(posedge clock) #1;

        // single op
        out_ready = 1'b1;
        send(8'd10, 8'd5, e);
        wait_idle();
        check("single_val", 32'(got[0]), 32'h005);
        check("single_ops", 32'(ops_done), 32'd1);

        // underflow and equal
        send(8'd3, 8'd10, e);
        send(8'd7, 8'd7, e);
        wait_idle();
        check("under_val", 32'(got[1]), 32'(EXP_3_10));
        check("equal_val", 32'(got[2]), 32'h000);

        // streaming
        do_reset();
        @(posedge clock) #1;
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send(8'(i + 20), 8'(i), e);
            check("stream_no_stall", 32'(e), 32'd1);
        end
        wait_idle();
        for (int i = 0; i < 8; i++) check("stream_val", 32'(got[i]), 32'd20);
        check("stream_ops", 32'(ops_done), 32'd8);

        // back-pressure
        base = got.size();
        out_ready = 1'b0;
        send(8'd11, 8'd10, e);
        send(8'd200, 8'd1, e);
        dataa = 8'd5;
        datab = 8'd9;
        in_valid = 1'b1;
        repeat (5) begin
            @(negedge clock);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_result", 32'(result), 32'd1);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clock) #1 out_ready = 1'b1;
        send(8'd5, 8'd9, e);
        wait_idle();
        check("bp_count", 32'(got.size() - base), 32'd3);
        check("bp_val0", 32'(got[base]), 32'h001);
        check("bp_val1", 32'(got[base+1]), 32'd199);
        check("bp_val2", 32'(got[base+2]), 32'(EXP_5_9));

        // reset with two ops in flight
        out_ready = 1'b0;
        send(8'd40, 8'd1, e);
        send(8'd41, 8'd2, e);
        do_reset();
        @(posedge clock) #1 out_ready = 1'b1;
        send(8'd50, 8'd8, e);
        wait_idle();
        check("post_rst_count", 32'(got.size()), 32'd1);
        check("post_rst_val", 32'(got[0]), 32'd42);
        check("post_rst_ops", 32'(ops_done), 32'd1);

        // counter wrap with a 4-bit counter
        do_reset();
        @(posedge clock) #1 out_ready = 1'b1;
        for (int i = 0; i < 17; i++) send(8'($urandom), 8'($urandom), e);
        wait_idle();
        check("wrap_ops", 32'(ops_done), 32'd1);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            @(posedge clock) #1;
            in_valid  = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 3) != 0);
            dataa     = 8'($urandom);
            datab     = ($urandom_range(0, 7) == 0) ? dataa : 8'($urandom);
        end
        @(posedge clock) #1;
        in_valid = 1'b0;
        out_ready = 1'b1;
        wait_idle();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
